pb_port_master: RTL

PB_PORT_MASTER -- requirements
Module: pb_port_master

---
 rtl/pb_port_master_pkg.sv | 19 +
 rtl/pb_cmd_fifo.sv | 55 +++++
 rtl/pb_port_master.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pb_port_master_pkg.sv
// Shared definitions for the port-bus master: FSM state encoding and command-queue entry layout.
package pb_port_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_IACK   = 2'd3
    } state_t;

    localparam int ENTRY_W = 17;

    typedef struct packed {
        logic       wr;
        logic [7:0] port;
        logic [7:0] data;
    } cmd_entry_t;

endpackage

// File: rtl/pb_cmd_fifo.sv
// Command queue for pb_port_master: power-of-two depth, registered count, no write-to-read bypass.
module pb_cmd_fifo
    import pb_port_master_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_rdata = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/pb_port_master.sv
// Port-bus master: queues read/write commands and plays them out as setup+strobe pairs, with interrupt acknowledge.
//   state  | meaning
//   IDLE   | waiting; interrupt wins over a queued command, else pop head
//   SETUP  | port_id/out_port valid, strobes low
//   STROBE | one-cycle write_strobe or read_strobe; read data captured at its end
//   IACK   | one-cycle interrupt_ack / irq_seen
module pb_port_master
    import pb_port_master_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter bit IRQ_ACK_EN = 1'b1
) (
    input  logic       sysclk,
    input  logic       sysreset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_port,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_port,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       irq_seen,
    output logic [7:0] port_id,
    output logic [7:0] out_port,
    input  logic [7:0] in_port,
    output logic       write_strobe,
    output logic       read_strobe,
    input  logic       interrupt,
    output logic       interrupt_ack
);

    state_t             r_state;
    state_t             w_next;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [ENTRY_W-1:0] w_head;
    cmd_entry_t         w_entry;
    logic               r_is_write;
    logic [7:0]         r_port_id;
    logic [7:0]         r_out_port;
    logic               r_rsp_valid;
    logic [7:0]         r_rsp_port;
    logic [7:0]         r_rsp_data;

    pb_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .i_clk   (sysclk),
        .i_rst_n (sysreset),
        .i_push  (cmd_valid),
        .i_wdata ({cmd_write, cmd_port, cmd_data}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_entry = cmd_entry_t'(w_head);

    always_ff @(posedge sysclk) begin
        if (!sysreset) r_state <= ST_IDLE;
        else           r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (interrupt && IRQ_ACK_EN) begin
                    w_next = ST_IACK;
                end else if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = ST_SETUP;
                end
            end
            ST_SETUP:  w_next = ST_STROBE;
            ST_STROBE: w_next = ST_IDLE;
            ST_IACK:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Bus registers load on the pop so they are already valid during SETUP.
    always_ff @(posedge sysclk) begin
        if (!sysreset) begin
            r_is_write  <= 1'b0;
            r_port_id   <= 8'h00;
            r_out_port  <= 8'h00;
            r_rsp_valid <= 1'b0;
            r_rsp_port  <= 8'h00;
            r_rsp_data  <= 8'h00;
        end else begin
            if (w_pop) begin
                r_is_write <= w_entry.wr;
                r_port_id  <= w_entry.port;
                if (w_entry.wr) r_out_port <= w_entry.data;
            end
            r_rsp_valid <= (r_state == ST_STROBE) && !r_is_write;
            if ((r_state == ST_STROBE) && !r_is_write) begin
                r_rsp_port <= r_port_id;
                r_rsp_data <= in_port;
            end
        end
    end

    always_comb begin
        write_strobe  = (r_state == ST_STROBE) && r_is_write;
        read_strobe   = (r_state == ST_STROBE) && !r_is_write;
        interrupt_ack = (r_state == ST_IACK);
        irq_seen      = (r_state == ST_IACK);
        busy          = (r_state != ST_IDLE) || !w_empty;
        cmd_ready     = !w_full;
    end

    assign port_id   = r_port_id;
    assign out_port  = r_out_port;
    assign rsp_valid = r_rsp_valid;
    assign rsp_port  = r_rsp_port;
    assign rsp_data  = r_rsp_data;

endmodule
